// File: rtl/ternary_match_pkg.sv
// Shared types for the ternary match table: FSM states, table entry layout
// and the single-entry match rule.
package ternary_match_pkg;

  localparam int TM_KEY_W = 3;
  localparam int TM_RES_W = 3;
  localparam int TM_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } tm_state_e;

  typedef struct packed {
    logic                valid;
    logic [TM_KEY_W-1:0] value;
    logic [TM_KEY_W-1:0] care;
    logic [TM_RES_W-1:0] result;
  } tm_entry_t;

  localparam tm_entry_t TM_ENTRY_RST = '{
    valid:  1'b0,
    value:  {TM_KEY_W{1'b0}},
    care:   {TM_KEY_W{1'b0}},
    result: {TM_RES_W{1'b0}}
  };

  // A cleared care bit turns the corresponding label bit into a wildcard.
  function automatic logic match(input logic [TM_KEY_W-1:0] key, input tm_entry_t e);
    match = e.valid && (((key ^ e.value) & e.care) == {TM_KEY_W{1'b0}});
  endfunction

endpackage

// File: rtl/ternary_match_cmp.sv
// Combinational comparator for one table entry against the latched key.
module ternary_match_cmp
  import ternary_match_pkg::*;
(
  input  logic [TM_KEY_W-1:0] key_i,
  input  tm_entry_t           entry_i,
  output logic                match_o
);

  assign match_o = match(key_i, entry_i);

endmodule

// File: rtl/ternary_match_table.sv
// Programmable ternary match table: sequential first-match scan over DEPTH
// entries, one entry per cycle, with a one-cycle registered response pulse.
module ternary_match_table
  import ternary_match_pkg::*;
#(
  parameter int KEY_W = TM_KEY_W,
  parameter int RES_W = TM_RES_W,
  parameter int DEPTH = TM_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [KEY_W-1:0] wr_value,
  input  logic [KEY_W-1:0] wr_care,
  input  logic [RES_W-1:0] wr_result,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_a,
  input  logic [KEY_W-1:0] req_b,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [RES_W-1:0] rsp_result
);

  tm_entry_t        table_q [DEPTH];
  tm_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  tm_entry_t        cur_entry_s;
  logic             cur_match_s;

  // Compare reads the registered table, so a same-cycle write lands after it.
  assign cur_entry_s = table_q[ptr_q];

  ternary_match_cmp u_cmp (
    .key_i   (key_q),
    .entry_i (cur_entry_s),
    .match_o (cur_match_s)
  );

  // Table storage: writes accepted in every FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= TM_ENTRY_RST;
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= '{valid: wr_valid, value: wr_value, care: wr_care, result: wr_result};
    end
  end

  // Next-state and response computation for the scan FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    key_d        = key_q;
    rsp_valid_d  = 1'b0;
    rsp_hit_d    = rsp_hit_q;
    rsp_idx_d    = rsp_idx_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          key_d   = req_a & req_b;
          ptr_d   = {IDX_W{1'b0}};
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cur_match_s) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_hit_d    = 1'b1;
          rsp_idx_d    = ptr_q;
          rsp_result_d = cur_entry_s.result;
        end else if (ptr_q == IDX_W'(DEPTH - 1)) begin
          // Miss leaves rsp_result untouched, like casex with no default arm.
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = {IDX_W{1'b0}};
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // FSM state, latched key and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= {IDX_W{1'b0}};
      key_q        <= {KEY_W{1'b0}};
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_idx_q    <= {IDX_W{1'b0}};
      rsp_result_q <= {RES_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      key_q        <= key_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_idx    = rsp_idx_q;
  assign rsp_result = rsp_result_q;

endmodule
